// File: rtl/tone_period_meter.sv
// Period and high-time meter for a square-wave tone, measured in clk cycles.
// Publishes each rise-to-rise measurement with a one-cycle strobe and tracks lock/loss of signal.
module tone_period_meter #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             rise;
  logic             wipe;
  logic             start_meas, done_meas, overflow;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [3:0]       mcnt, mcnt_next;

  assign wipe = rst | clr;
  assign rise = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (wipe) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: if (!rise && cnt == CNT_MAX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_meas = 1'b0;
    done_meas  = 1'b0;
    overflow   = 1'b0;
    case (state)
      IDLE:    start_meas = rise;
      MEASURE: begin
        done_meas = rise;
        overflow  = !rise && (cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  // A zero match count means no period has been published since IDLE, so the stale one is ignored.
  always_comb begin
    mcnt_next = 4'd1;
    if (mcnt != 4'd0 && cnt == period) begin
      if (mcnt >= LOCK_V) mcnt_next = LOCK_V;
      else                mcnt_next = mcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      no_signal <= 1'b1;
      mcnt      <= 4'd0;
    end else begin
      valid <= done_meas;

      if (start_meas || done_meas) begin
        cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
        hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (state == MEASURE && !overflow) begin
        cnt <= cnt + 1'b1;
        if (s2) hcnt <= hcnt + 1'b1;
      end else begin
        cnt  <= '0;
        hcnt <= '0;
      end

      if (done_meas) begin
        period    <= cnt;
        high_time <= hcnt;
        no_signal <= 1'b0;
        mcnt      <= mcnt_next;
        locked    <= (mcnt_next >= LOCK_V);
      end

      if (overflow) begin
        no_signal <= 1'b1;
        locked    <= 1'b0;
        mcnt      <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// Randomized scoreboard bench for tone_period_meter against a rise-timestamp reference model.
// The model works on the sample stream as driven; the DUT shows each sample's effect 3 edges later.
module tb_tone_period_meter;

  localparam int CNT_W    = 6;
  localparam int LOCK_CNT = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;
  localparam int HIST     = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             no_signal;

  tone_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .clr(clr),
    .period(period), .high_time(high_time), .valid(valid),
    .locked(locked), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  typedef struct packed { int per; int hi; bit lck; } exp_t;

  exp_t expQ[$];
  exp_t popped;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   d0 = 0;
  bit   started = 1'b0;

  bit   measuring, mLock, mNosig, prevV;
  int   startIdx, hiAcc, runLen, mPer, mHigh, zeroLeft;
  bit   clrAt[HIST];
  int   histPer[HIST], histHigh[HIST];
  bit   histLock[HIST], histNosig[HIST], histValid[HIST];
  int   th, tl, reps;
  bit   tc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d required %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic checkOutput();
    int h;
    h = cyc - 3;
    if (started && h >= d0) begin
      checkValue("period", int'(period), histPer[h]);
      checkValue("high_time", int'(high_time), histHigh[h]);
      checkValue("valid", int'(valid), int'(histValid[h]));
      checkValue("locked", int'(locked), int'(histLock[h]));
      checkValue("no_signal", int'(no_signal), int'(histNosig[h]));
    end
  endtask

  // Reference: a measurement is the distance between consecutive rises of the stream the DUT sees;
  // a clear blanks the three samples already inside the synchronizer.
  task automatic modelIndex(input int d, input bit s, input bit c);
    bit v, rise, pushed;
    int newPer;
    pushed = 1'b0;
    v = s;
    if (zeroLeft > 0) begin
      v = 1'b0;
      zeroLeft--;
    end
    if (c) begin
      measuring = 1'b0; runLen = 0; mPer = 0; mHigh = 0;
      mLock = 1'b0; mNosig = 1'b1; zeroLeft = 2; v = 1'b0;
    end else begin
      rise = v && !prevV;
      if (measuring && rise) begin
        newPer = d - startIdx;
        if (runLen == 0 || newPer != mPer) runLen = 1;
        else if (runLen < LOCK_CNT)        runLen++;
        mPer = newPer;
        mHigh = hiAcc;
        mLock = (runLen >= LOCK_CNT);
        mNosig = 1'b0;
        expQ.push_back('{mPer, mHigh, mLock});
        pushed = 1'b1;
        startIdx = d;
        hiAcc = 0;
      end else if (measuring && (d - startIdx) == MAXC) begin
        measuring = 1'b0; runLen = 0; mLock = 1'b0; mNosig = 1'b1;
      end else if (!measuring && rise) begin
        measuring = 1'b1; startIdx = d; hiAcc = 0;
      end
      if (measuring && v) hiAcc++;
    end
    prevV = v;
    histPer[d] = mPer;
    histHigh[d] = mHigh;
    histLock[d] = mLock;
    histNosig[d] = mNosig;
    histValid[d] = pushed;
  endtask

  task automatic applyStimulus(input bit s, input bit c);
    @(negedge clk);
    checkOutput();
    sig_in = s;
    clrAt[cyc] = c;
    clr = (cyc - 2 >= d0) ? clrAt[cyc - 2] : 1'b0;
    modelIndex(cyc, s, c);
  endtask

  task automatic playTone(input int h, input int l, input bit clrOnRise);
    for (int i = 0; i < h; i++) applyStimulus(1'b1, clrOnRise && i == 0);
    for (int i = 0; i < l; i++) applyStimulus(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_valid: actual period %0d, required no strobe at cycle %0d", period, cyc);
      end else begin
        popped = expQ.pop_front();
        checkValue("sb_period", int'(period), popped.per);
        checkValue("sb_high_time", int'(high_time), popped.hi);
        checkValue("sb_locked", int'(locked), int'(popped.lck));
        checkValue("sb_no_signal", int'(no_signal), 0);
      end
    end
  end

  initial begin
    rst = 1'b1; sig_in = 1'b0; clr = 1'b0;
    measuring = 1'b0; mLock = 1'b0; mNosig = 1'b1; prevV = 1'b0;
    startIdx = 0; hiAcc = 0; runLen = 0; mPer = 0; mHigh = 0; zeroLeft = 0;
    repeat (3) @(negedge clk);
    checkValue("rst_period", int'(period), 0);
    checkValue("rst_high_time", int'(high_time), 0);
    checkValue("rst_valid", int'(valid), 0);
    checkValue("rst_locked", int'(locked), 0);
    checkValue("rst_no_signal", int'(no_signal), 1);
    rst = 1'b0;
    d0 = cyc + 1;
    started = 1'b1;

    repeat (5) playTone(8, 8, 1'b0);
    checkValue("tone16_period", int'(period), 16);
    checkValue("tone16_high", int'(high_time), 8);
    checkValue("tone16_locked", int'(locked), 1);

    playTone(10, 8, 1'b0);
    repeat (4) playTone(8, 8, 1'b0);

    applyStimulus(1'b1, 1'b0);
    repeat (80) applyStimulus(1'b0, 1'b0);
    checkValue("ovf_no_signal", int'(no_signal), 1);
    checkValue("ovf_locked", int'(locked), 0);
    checkValue("ovf_period", int'(period), 16);
    repeat (2) playTone(8, 8, 1'b0);

    repeat (3) playTone(10, 53, 1'b0);
    playTone(10, 54, 1'b0);
    playTone(10, 53, 1'b0);

    repeat (4) playTone(8, 8, 1'b0);
    playTone(8, 8, 1'b1);
    repeat (3) playTone(8, 8, 1'b0);

    repeat (5) playTone(4, 12, 1'b0);

    for (int t = 0; t < 30; t++) begin
      th = $urandom_range(1, 20);
      tl = $urandom_range(1, 24);
      reps = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) tl = $urandom_range(50, 70);
      for (int r = 0; r < reps; r++) begin
        tc = ($urandom_range(0, 15) == 0);
        playTone(th, tl, tc);
      end
    end

    repeat (6) applyStimulus(1'b0, 1'b0);
    checkValue("queue_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
